// File: rtl/vec_max_streamer_pkg.sv
// -----------------------------------------------------------------------------
// vec_max_streamer_pkg
// Shared types and constants for the per-vector max streamer.
//   - Default frame geometry (vectors per frame, sample width).
//   - FSM state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
//   - idx_width(): width of the argmax index for a given vector length.
// The optional argmax output is enabled with the macro VEC_MAX_ARGMAX_EN.
// -----------------------------------------------------------------------------
package vec_max_streamer_pkg;

  localparam int CFG_IMG_VEC_NUM = 3;
  localparam int CFG_VEC_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vm_state_e;

  // A single-sample vector still carries a 1-bit index so the port never
  // collapses to zero width.
  function automatic int idx_width(input int vec_len);
    if (vec_len <= 1) begin
      return 1;
    end else begin
      return $clog2(vec_len);
    end
  endfunction

endpackage

// File: rtl/vec_max_if.sv
// -----------------------------------------------------------------------------
// vec_max_if
// Sample input stream and max-value output stream of vec_max_streamer.
//   s_valid/s_ready/s_data           : raw samples into the reducer
//   m_valid/m_ready/m_value/m_last   : per-vector maxima out of the FIFO
//   m_index (VEC_MAX_ARGMAX_EN only) : position of the first maximum
// Modports: slave = streamer view, master = producer/consumer view.
// -----------------------------------------------------------------------------
interface vec_max_if #(
  parameter int VALUE_WIDTH = 8
`ifdef VEC_MAX_ARGMAX_EN
  , parameter int IDX_W = 1
`endif
);

  logic                   s_valid;
  logic                   s_ready;
  logic [VALUE_WIDTH-1:0] s_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [VALUE_WIDTH-1:0] m_value;
  logic                   m_last;
`ifdef VEC_MAX_ARGMAX_EN
  logic [IDX_W-1:0]       m_index;
`endif

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_value, m_last
`ifdef VEC_MAX_ARGMAX_EN
    , output m_index
`endif
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_value, m_last
`ifdef VEC_MAX_ARGMAX_EN
    , input m_index
`endif
  );

endinterface

// File: rtl/vec_max_streamer_fifo.sv
// -----------------------------------------------------------------------------
// vm_sync_fifo
// Synchronous first-word-fall-through FIFO with a registered head.
//   clk, rst             : clock, synchronous active-high reset
//   wr_en_i, wr_data_i   : push request and data (ignored when full)
//   full_o               : no free entry
//   rd_en_i              : pop request (ignored when empty)
//   rd_data_o            : current head; holds the last head while empty
//   empty_o              : no entry available
// -----------------------------------------------------------------------------
module vm_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_s, pop_s;

  // Pointer, occupancy and head-register next-state logic.
  always_comb begin
    push_s   = wr_en_i && (count_q != CW'(DEPTH));
    pop_s    = rd_en_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    // The new head is the incoming word whenever it lands in an otherwise
    // empty queue; else it is the storage slot the read pointer will address.
    // An empty queue keeps the previous head visible.
    if (count_d == '0) begin
      head_d = head_q;
    end else if ((count_q == '0) || (pop_s && (count_q == CW'(1)))) begin
      head_d = wr_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Control and head registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Entry storage; contents are only read once written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = head_q;

endmodule

// File: rtl/vec_max_streamer.sv
// -----------------------------------------------------------------------------
// vec_max_streamer
// Reduces every VEC_LEN input samples to their unsigned maximum and streams
// IMG_VEC_N maxima per frame through a small FIFO with valid/ready/last.
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle pulse, arms a frame (IDLE only)
//   bus (slave) : s_valid/s_ready/s_data sample input,
//                 m_valid/m_ready/m_value/m_last max output,
//                 m_index when VEC_MAX_ARGMAX_EN is defined
//   busy        : frame in progress (RUN or DRAIN)
//   done        : one-cycle pulse once the last maximum has left the FIFO
// Optional feature macro: VEC_MAX_ARGMAX_EN (argmax index carried with value).
// -----------------------------------------------------------------------------
module vec_max_streamer
  import vec_max_streamer_pkg::*;
#(
  parameter int IMG_VEC_N   = CFG_IMG_VEC_NUM,
  parameter int VALUE_WIDTH = CFG_VEC_WIDTH,
  parameter int VEC_LEN     = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  vec_max_if.slave bus,
  output logic     busy,
  output logic     done
);

  localparam int EW = $clog2(VEC_LEN + 1);
  localparam int VW = $clog2(IMG_VEC_N + 1);
`ifdef VEC_MAX_ARGMAX_EN
  localparam int IW      = idx_width(VEC_LEN);
  localparam int ENTRY_W = VALUE_WIDTH + 1 + IW;
`else
  localparam int ENTRY_W = VALUE_WIDTH + 1;
`endif

  vm_state_e              state_q, state_d;
  logic [EW-1:0]          elem_cnt_q, elem_cnt_d;
  logic [VW-1:0]          vec_cnt_q, vec_cnt_d;
  logic [VALUE_WIDTH-1:0] run_max_q, run_max_d;
  logic [VALUE_WIDTH-1:0] merged_max_s;
`ifdef VEC_MAX_ARGMAX_EN
  logic [IW-1:0]          run_idx_q, run_idx_d;
  logic [IW-1:0]          merged_idx_s;
`endif
  logic                   last_flag_s;
  logic                   s_ready_s;
  logic                   push_s;
  logic                   done_s;
  logic [ENTRY_W-1:0]     push_data_s;
  logic [ENTRY_W-1:0]     head_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;

  // Running maximum merged with the current sample; the first sample of a
  // vector replaces whatever the previous vector left behind.
  always_comb begin
    merged_max_s = run_max_q;
`ifdef VEC_MAX_ARGMAX_EN
    merged_idx_s = run_idx_q;
`endif
    if (elem_cnt_q == '0) begin
      merged_max_s = bus.s_data;
`ifdef VEC_MAX_ARGMAX_EN
      merged_idx_s = '0;
`endif
    end else if (bus.s_data > run_max_q) begin
      // Strict compare: a later equal sample keeps the first position.
      merged_max_s = bus.s_data;
`ifdef VEC_MAX_ARGMAX_EN
      merged_idx_s = IW'(elem_cnt_q);
`endif
    end else begin
      merged_max_s = run_max_q;
`ifdef VEC_MAX_ARGMAX_EN
      merged_idx_s = run_idx_q;
`endif
    end

    last_flag_s = (vec_cnt_q == VW'(IMG_VEC_N - 1));
`ifdef VEC_MAX_ARGMAX_EN
    push_data_s = {merged_idx_s, last_flag_s, merged_max_s};
`else
    push_data_s = {last_flag_s, merged_max_s};
`endif
  end

  // FSM next-state, counters and handshake outputs.
  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    run_max_d  = run_max_q;
`ifdef VEC_MAX_ARGMAX_EN
    run_idx_d  = run_idx_q;
`endif
    s_ready_s  = 1'b0;
    push_s     = 1'b0;
    done_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          elem_cnt_d = '0;
          vec_cnt_d  = '0;
          run_max_d  = '0;
`ifdef VEC_MAX_ARGMAX_EN
          run_idx_d  = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Stalling on a full FIFO even mid-vector keeps the final push safe.
        s_ready_s = !fifo_full_s && (vec_cnt_q < VW'(IMG_VEC_N));
        if (s_ready_s && bus.s_valid) begin
          run_max_d = merged_max_s;
`ifdef VEC_MAX_ARGMAX_EN
          run_idx_d = merged_idx_s;
`endif
          if (elem_cnt_q == EW'(VEC_LEN - 1)) begin
            push_s     = 1'b1;
            elem_cnt_d = '0;
            vec_cnt_d  = vec_cnt_q + VW'(1);
            if (last_flag_s) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            elem_cnt_d = elem_cnt_q + EW'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_DRAIN: begin
        if (fifo_empty_s) begin
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and running-max registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      elem_cnt_q <= '0;
      vec_cnt_q  <= '0;
      run_max_q  <= '0;
`ifdef VEC_MAX_ARGMAX_EN
      run_idx_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      run_max_q  <= run_max_d;
`ifdef VEC_MAX_ARGMAX_EN
      run_idx_q  <= run_idx_d;
`endif
    end
  end

  vm_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push_s),
    .wr_data_i (push_data_s),
    .full_o    (fifo_full_s),
    .rd_en_i   (bus.m_ready),
    .rd_data_o (head_s),
    .empty_o   (fifo_empty_s)
  );

  assign bus.s_ready = s_ready_s;
  assign bus.m_valid = !fifo_empty_s;
  assign bus.m_value = head_s[VALUE_WIDTH-1:0];
  assign bus.m_last  = head_s[VALUE_WIDTH];
`ifdef VEC_MAX_ARGMAX_EN
  assign bus.m_index = head_s[ENTRY_W-1 -: IW];
`endif
  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done = done_s;

endmodule

// File: tb/tb_vec_max_streamer.sv
// -----------------------------------------------------------------------------
// tb_vec_max_streamer
// Self-checking bench: a 3-vector instance for the main scenarios and an
// 8-vector instance for FIFO-full behaviour. Expected maxima come from a
// plain per-vector reduction of the stimulus queue.
// -----------------------------------------------------------------------------
module tb_vec_max_streamer;
  import vec_max_streamer_pkg::*;

  localparam int VW  = 8;
  localparam int VL  = 4;
  localparam int NV  = 3;
  localparam int NV8 = 8;
  localparam int DEP = 4;
`ifdef VEC_MAX_ARGMAX_EN
  localparam int IW = idx_width(VL);
`endif

  logic clk = 1'b0;
  logic rst, start, start8, busy, done, busy8, done8;

  always #5 clk = ~clk;

  vec_max_if #(.VALUE_WIDTH(VW)
`ifdef VEC_MAX_ARGMAX_EN
    , .IDX_W(IW)
`endif
  ) bus ();
  vec_max_if #(.VALUE_WIDTH(VW)
`ifdef VEC_MAX_ARGMAX_EN
    , .IDX_W(IW)
`endif
  ) bus8 ();

  vec_max_streamer #(.IMG_VEC_N(NV), .VALUE_WIDTH(VW), .VEC_LEN(VL), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.slave), .busy(busy), .done(done));
  vec_max_streamer #(.IMG_VEC_N(NV8), .VALUE_WIDTH(VW), .VEC_LEN(VL), .FIFO_DEPTH(DEP)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bus(bus8.slave), .busy(busy8), .done(done8));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
  int obs_val[$], obs_last[$], obs_idx[$], obs8_val[$];
  int stim_q[$];
  int exp_val[$], exp_last[$], exp_idx[$];

  // Output monitor: records handshakes and done pulses mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.m_valid && bus.m_ready) begin
      obs_val.push_back(int'(bus.m_value));
      obs_last.push_back(int'(bus.m_last));
`ifdef VEC_MAX_ARGMAX_EN
      obs_idx.push_back(int'(bus.m_index));
`endif
      if (bus.m_last) last_hs_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus8.m_valid && bus8.m_ready) obs8_val.push_back(int'(bus8.m_value));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic int rnd_sample();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Reference: max and first position of each group of VL samples.
  task automatic build_expected(input int nvec);
    exp_val.delete();
    exp_last.delete();
    exp_idx.delete();
    for (int v = 0; v < nvec; v++) begin
      int m, idx;
      m = stim_q[v*VL];
      idx = 0;
      for (int e = 1; e < VL; e++) begin
        if (stim_q[v*VL+e] > m) begin
          m = stim_q[v*VL+e];
          idx = e;
        end
      end
      exp_val.push_back(m);
      exp_last.push_back((v == nvec - 1) ? 1 : 0);
      exp_idx.push_back(idx);
    end
  endtask

  task automatic clear_obs();
    obs_val.delete();
    obs_last.delete();
    obs_idx.delete();
    obs8_val.delete();
  endtask

  task automatic feed(input int lo, input int hi, input bit gaps, input bit rr);
    int i, guard;
    bit acc;
    i = lo;
    guard = 0;
    while (i < hi && guard < 3000) begin
      bus.s_data  = 8'(stim_q[i]);
      bus.s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rr) bus.m_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      tick();
      if (acc) i++;
      guard++;
    end
    bus.s_valid = 1'b0;
    n_tests++;
    if (i < hi) begin
      n_fail++;
      $display("FAIL feed_timeout: accepted %0d expected %0d", i - lo, hi - lo);
    end
  endtask

  task automatic wait_done(input bit rr, input int d0);
    int guard;
    guard = 0;
    while (done_cnt == d0 && guard < 500) begin
      if (rr) bus.m_ready = ($urandom_range(0, 1) == 1);
      tick();
      guard++;
    end
    bus.m_ready = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (done_cnt !== d0 + 1) begin
      n_fail++;
      $display("FAIL done_pulses: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    bus8.s_valid = 1'b0; bus8.s_data = '0; bus8.m_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    bus.m_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 6;
    if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 0", bus.s_ready); end
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
    if (bus.m_value !== 8'd0) begin n_fail++; $display("FAIL reset_m_value: got %0d expected 0", bus.m_value); end
    if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b expected 0", bus.m_last); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
  endtask

  task automatic test_basic();
    int d0;
    stim_q = '{3, 9, 2, 7, 0, 0, 0, 0, 255, 1, 255, 4};
    build_expected(NV);
    clear_obs();
    d0 = done_cnt;
    bus.m_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < NV*VL; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(stim_q[i]);
      @(negedge clk);
      n_tests++;
      if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL basic_s_ready[%0d]: got %b expected 1", i, bus.s_ready); end
      if (i % VL == VL - 1) begin
        n_tests++;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty[%0d]: got %b expected 0", i, bus.m_valid); end
      end
      if (i > 0 && i % VL == 0) begin
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_value !== 8'(exp_val[i/VL-1])) begin
          n_fail++;
          $display("FAIL basic_latency[%0d]: got v%b %0d expected v1 %0d", i, bus.m_valid, bus.m_value, exp_val[i/VL-1]);
        end
      end
      tick();
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.m_valid !== 1'b1 || bus.m_value !== 8'd255 || bus.m_last !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_last: got v%b %0d l%b d%b expected v1 255 l1 d0", bus.m_valid, bus.m_value, bus.m_last, done);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_done: got d%b b%b expected d1 b1", done, busy); end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got d%b b%b expected d0 b0", done, busy); end
    n_tests++;
    if (done_cyc !== last_hs_cyc + 1 || done_cnt !== d0 + 1) begin
      n_fail++;
      $display("FAIL basic_done_timing: got cycle %0d count %0d expected cycle %0d count %0d", done_cyc, done_cnt - d0, last_hs_cyc + 1, 1);
    end
    n_tests++;
    if (obs_val.size() != exp_val.size()) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", obs_val.size(), exp_val.size()); end
    for (int k = 0; k < exp_val.size() && k < obs_val.size(); k++) begin
      n_tests++;
      if (obs_val[k] !== exp_val[k] || obs_last[k] !== exp_last[k]) begin
        n_fail++;
        $display("FAIL basic_out[%0d]: got %0d last %0d expected %0d last %0d", k, obs_val[k], obs_last[k], exp_val[k], exp_last[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int d0, stalls;
    stim_q = '{3, 9, 2, 7, 0, 0, 0, 0, 255, 1, 255, 4};
    build_expected(NV);
    clear_obs();
    d0 = done_cnt;
    stalls = 0;
    bus.m_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < NV*VL; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(stim_q[i]);
      @(negedge clk);
      if (bus.s_ready !== 1'b1) stalls++;
      tick();
    end
    bus.s_valid = 1'b1;
    n_tests++;
    if (stalls != 0) begin n_fail++; $display("FAIL bp_stalls: got %0d expected 0", stalls); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_value !== 8'(exp_val[0]) || bus.m_last !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got r%b v%b %0d l%b expected r0 v1 %0d l0", c, bus.s_ready, bus.m_valid, bus.m_value, bus.m_last, exp_val[0]);
      end
      tick();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    wait_done(1'b0, d0);
    n_tests++;
    if (obs_val.size() != exp_val.size()) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", obs_val.size(), exp_val.size()); end
    for (int k = 0; k < exp_val.size() && k < obs_val.size(); k++) begin
      n_tests++;
      if (obs_val[k] !== exp_val[k] || obs_last[k] !== exp_last[k]) begin
        n_fail++;
        $display("FAIL bp_out[%0d]: got %0d last %0d expected %0d last %0d", k, obs_val[k], obs_last[k], exp_val[k], exp_last[k]);
      end
    end
  endtask

  task automatic test_random();
    int d0;
    for (int f = 0; f < 4; f++) begin
      stim_q.delete();
      for (int i = 0; i < NV*VL; i++) stim_q.push_back(rnd_sample());
      build_expected(NV);
      clear_obs();
      d0 = done_cnt;
      pulse_start();
      feed(0, NV*VL, 1'b1, 1'b1);
      wait_done(1'b1, d0);
      n_tests++;
      if (obs_val.size() != exp_val.size()) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", f, obs_val.size(), exp_val.size()); end
      for (int k = 0; k < exp_val.size() && k < obs_val.size(); k++) begin
        n_tests++;
        if (obs_val[k] !== exp_val[k] || obs_last[k] !== exp_last[k]) begin
          n_fail++;
          $display("FAIL rand_out[%0d][%0d]: got %0d last %0d expected %0d last %0d", f, k, obs_val[k], obs_last[k], exp_val[k], exp_last[k]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int d0, guard, idle_ready;
    stim_q.delete();
    for (int i = 0; i < NV*VL; i++) stim_q.push_back(rnd_sample());
    build_expected(NV);
    clear_obs();
    d0 = done_cnt;
    bus.m_ready = 1'b1;
    pulse_start();
    feed(0, 6, 1'b0, 1'b0);
    pulse_start();
    bus.m_ready = 1'b0;
    feed(6, NV*VL, 1'b0, 1'b0);
    // Hold start high through DRAIN, including the done cycle.
    start = 1'b1;
    bus.m_ready = 1'b1;
    guard = 0;
    while (done_cnt == d0 && guard < 100) begin
      tick();
      guard++;
    end
    start = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || done_cnt !== d0 + 1) begin n_fail++; $display("FAIL ign_busy: got b%b pulses %0d expected b0 pulses 1", busy, done_cnt - d0); end
    n_tests++;
    if (obs_val.size() != exp_val.size()) begin n_fail++; $display("FAIL ign_count: got %0d expected %0d", obs_val.size(), exp_val.size()); end
    for (int k = 0; k < exp_val.size() && k < obs_val.size(); k++) begin
      n_tests++;
      if (obs_val[k] !== exp_val[k] || obs_last[k] !== exp_last[k]) begin
        n_fail++;
        $display("FAIL ign_out[%0d]: got %0d last %0d expected %0d last %0d", k, obs_val[k], obs_last[k], exp_val[k], exp_last[k]);
      end
    end
    idle_ready = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'd77;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0) idle_ready++;
      tick();
    end
    bus.s_valid = 1'b0;
    n_tests++;
    if (idle_ready != 0 || obs_val.size() != exp_val.size() || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_samples: got %0d bad cycles %0d outputs busy %b expected 0 %0d 0", idle_ready, obs_val.size(), busy, exp_val.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    stim_q = '{10, 40, 20, 30, 5, 6};
    clear_obs();
    d0 = done_cnt;
    bus.m_ready = 1'b0;
    pulse_start();
    feed(0, 6, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (bus.m_valid !== 1'b1 || bus.m_value !== 8'd40) begin n_fail++; $display("FAIL mid_buffered: got v%b %0d expected v1 40", bus.m_valid, bus.m_value); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (bus.m_valid !== 1'b0 || busy !== 1'b0 || bus.m_value !== 8'd0 || bus.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got v%b b%b %0d r%b expected v0 b0 0 r0", bus.m_valid, busy, bus.m_value, bus.s_ready);
    end
    tick();
    n_tests++;
    if (done_cnt !== d0) begin n_fail++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt - d0); end
    stim_q = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4};
    build_expected(NV);
    clear_obs();
    d0 = done_cnt;
    bus.m_ready = 1'b1;
    pulse_start();
    feed(0, NV*VL, 1'b1, 1'b0);
    wait_done(1'b0, d0);
    n_tests++;
    if (obs_val.size() != 3) begin n_fail++; $display("FAIL mid_count: got %0d expected 3", obs_val.size()); end
    for (int k = 0; k < 3 && k < obs_val.size(); k++) begin
      n_tests++;
      if (obs_val[k] !== 4 || obs_last[k] !== exp_last[k]) begin
        n_fail++;
        $display("FAIL mid_out[%0d]: got %0d last %0d expected 4 last %0d", k, obs_val[k], obs_last[k], exp_last[k]);
      end
    end
  endtask

  task automatic drive8(input int ncyc, inout int acc);
    bit took;
    for (int c = 0; c < ncyc; c++) begin
      bus8.s_valid = (acc < NV8*VL);
      bus8.s_data  = (acc < NV8*VL) ? 8'(stim_q[acc]) : 8'd0;
      @(negedge clk);
      took = bus8.s_valid && bus8.s_ready;
      tick();
      if (took) acc++;
    end
    bus8.s_valid = 1'b0;
  endtask

  task automatic test_full();
    int acc, guard;
    stim_q.delete();
    for (int i = 0; i < NV8*VL; i++) stim_q.push_back(rnd_sample());
    build_expected(NV8);
    clear_obs();
    acc = 0;
    bus8.m_ready = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    drive8(30, acc);
    @(negedge clk);
    n_tests++;
    if (acc != 4*VL || bus8.s_ready !== 1'b0 || bus8.m_value !== 8'(exp_val[0])) begin
      n_fail++;
      $display("FAIL full_stall: got acc %0d r%b %0d expected acc %0d r0 %0d", acc, bus8.s_ready, bus8.m_value, 4*VL, exp_val[0]);
    end
    tick();
    bus8.m_ready = 1'b1;
    tick();
    bus8.m_ready = 1'b0;
    drive8(30, acc);
    n_tests++;
    if (acc != 5*VL || obs8_val.size() != 1 || bus8.m_value !== 8'(exp_val[1])) begin
      n_fail++;
      $display("FAIL full_one_pop: got acc %0d pops %0d head %0d expected acc %0d pops 1 head %0d", acc, obs8_val.size(), bus8.m_value, 5*VL, exp_val[1]);
    end
    bus8.m_ready = 1'b1;
    drive8(60, acc);
    guard = 0;
    while (busy8 && guard < 100) begin
      tick();
      guard++;
    end
    n_tests++;
    if (busy8 !== 1'b0 || acc != NV8*VL) begin n_fail++; $display("FAIL full_finish: got busy %b acc %0d expected busy 0 acc %0d", busy8, acc, NV8*VL); end
    n_tests++;
    if (obs8_val.size() != exp_val.size()) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", obs8_val.size(), exp_val.size()); end
    for (int k = 0; k < exp_val.size() && k < obs8_val.size(); k++) begin
      n_tests++;
      if (obs8_val[k] !== exp_val[k]) begin n_fail++; $display("FAIL full_out[%0d]: got %0d expected %0d", k, obs8_val[k], exp_val[k]); end
    end
  endtask

`ifdef VEC_MAX_ARGMAX_EN
  task automatic test_argmax();
    int d0;
    stim_q = '{5, 8, 8, 1, 3, 3, 3, 3, 0, 7, 9, 9};
    build_expected(NV);
    clear_obs();
    d0 = done_cnt;
    bus.m_ready = 1'b1;
    pulse_start();
    feed(0, NV*VL, 1'b1, 1'b0);
    wait_done(1'b0, d0);
    n_tests++;
    if (obs_idx.size() != exp_idx.size()) begin n_fail++; $display("FAIL argmax_count: got %0d expected %0d", obs_idx.size(), exp_idx.size()); end
    for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
      n_tests++;
      if (obs_idx[k] !== exp_idx[k] || obs_val[k] !== exp_val[k]) begin
        n_fail++;
        $display("FAIL argmax_out[%0d]: got %0d@%0d expected %0d@%0d", k, obs_val[k], obs_idx[k], exp_val[k], exp_idx[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_start_ignored();
    test_reset_mid();
`ifdef VEC_MAX_ARGMAX_EN
    test_argmax();
`endif
    test_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
